// File: rtl/div_unit_if.sv
// Request/response bundle between the execute-stage control path and the
// iterative divider.
interface div_unit_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [1:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, op, a, b, flush,
      input  busy, done, result
   );

   modport slave (
      input  start, op, a, b, flush,
      output busy, done, result
   );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
//
// state | meaning
// IDLE  | waiting for start; operands latched on the accepting edge
// PREP  | sign flags, absolute values, special-case detection
// CALC  | XLEN shift/compare/subtract iterations
// FIN   | sign-correct and register result, pulse done
module div_unit #(
   parameter int XLEN = 32
) (
   input  logic       clk,
   input  logic       rst,
   div_unit_if.slave  bus
);
   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, PREP, CALC, FIN} state_t;

   state_t          state;
   state_t          state_nx;
   logic [XLEN-1:0] a_r;
   logic [XLEN-1:0] b_r;
   logic [1:0]      op_r;
   logic            neg_q;
   logic            neg_r;
   logic            special;
   logic [XLEN-1:0] dvd;
   logic [XLEN-1:0] dsr;
   logic [XLEN-1:0] rem;
   logic [CW-1:0]   count;
   logic [XLEN-1:0] result_r;
   logic            done_r;

   logic            signed_op;
   logic            sign_a;
   logic            sign_b;
   logic            div0;
   logic            ovf;
   logic [XLEN:0]   trial;
   logic [XLEN:0]   diff;
   logic            take;

   assign signed_op = ~op_r[0];
   assign sign_a    = signed_op & a_r[XLEN-1];
   assign sign_b    = signed_op & b_r[XLEN-1];
   assign div0      = (b_r == '0);
   assign ovf       = signed_op && (a_r == {1'b1, {(XLEN-1){1'b0}}}) && (b_r == '1);

   // Partial remainder is kept one bit wider here so unsigned divisors with
   // the top bit set still compare correctly.
   assign trial = {rem, dvd[XLEN-1]};
   assign diff  = trial - {1'b0, dsr};
   assign take  = (trial >= {1'b0, dsr});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (bus.start) state_nx = PREP;
         PREP: state_nx = (div0 || ovf) ? FIN : CALC;
         CALC: if (count == CW'(XLEN-1)) state_nx = FIN;
         FIN:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (state != IDLE && bus.flush) state_nx = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r      <= '0;
         b_r      <= '0;
         op_r     <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         special  <= 1'b0;
         dvd      <= '0;
         dsr      <= '0;
         rem      <= '0;
         count    <= '0;
         result_r <= '0;
         done_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_r  <= bus.a;
                  b_r  <= bus.b;
                  op_r <= bus.op;
               end
            end
            PREP: begin
               neg_q   <= sign_a ^ sign_b;
               neg_r   <= sign_a;
               special <= div0 | ovf;
               dsr     <= sign_b ? -b_r : b_r;
               count   <= '0;
               // Special cases park their final quotient/remainder in dvd/rem.
               if (div0) begin
                  dvd <= '1;
                  rem <= a_r;
               end else if (ovf) begin
                  dvd <= {1'b1, {(XLEN-1){1'b0}}};
                  rem <= '0;
               end else begin
                  dvd <= sign_a ? -a_r : a_r;
                  rem <= '0;
               end
            end
            CALC: begin
               dvd   <= {dvd[XLEN-2:0], take};
               rem   <= take ? diff[XLEN-1:0] : trial[XLEN-1:0];
               count <= count + CW'(1);
            end
            FIN: begin
               if (!bus.flush) begin
                  done_r <= 1'b1;
                  if (op_r[1])
                     result_r <= (special || !neg_r) ? rem : -rem;
                  else
                     result_r <= (special || !neg_q) ? dvd : -dvd;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy   = (state != IDLE);
   assign bus.done   = done_r;
   assign bus.result = result_r;
endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized checks of div_unit against an arithmetic reference.
module tb_div_unit;
   localparam int XLEN = 32;
   localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_bad = 0;

   div_unit_if #(.XLEN(XLEN)) bus ();

   div_unit #(.XLEN(XLEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      int sx = int'(x);
      int sy = int'(y);
      if (y == 0) return o[1] ? x : 32'hFFFF_FFFF;
      if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
      case (o)
         OP_DIV:  return 32'(sx / sy);
         OP_DIVU: return x / y;
         OP_REM:  return 32'(sx % sy);
         default: return x % y;
      endcase
   endfunction

   function automatic int ref_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      if (y == 0) return 2;
      if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 2;
      return XLEN + 2;
   endfunction

   // Drives one start edge, then scrambles the operand inputs.
   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      bus.start = 1'b1;
      bus.op    = o;
      bus.a     = x;
      bus.b     = y;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.op    = 2'($urandom);
      bus.a     = $urandom;
      bus.b     = $urandom;
   endtask

   task automatic wait_done(input string tag, input logic [31:0] exp_res, input int exp_lat);
      int n = 0;
      int busy_low = 0;
      while (!bus.done && n < 200) begin
         @(posedge clk);
         #1;
         n++;
         if (!bus.done && !bus.busy) busy_low++;
      end
      chk({tag, "_lat"}, n, exp_lat);
      chk({tag, "_res"}, bus.result, exp_res);
      chk({tag, "_busyhold"}, busy_low, 0);
      chk({tag, "_busyfin"}, {31'd0, bus.busy}, 0);
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [31:0] prev;
      prev = bus.result;
      issue(o, x, y);
      chk({tag, "_busy0"}, {31'd0, bus.busy}, 1);
      chk({tag, "_held"}, bus.result, prev);
      wait_done(tag, ref_res(o, x, y), ref_lat(o, x, y));
      @(posedge clk);
      #1;
      chk({tag, "_pulse"}, {31'd0, bus.done}, 0);
   endtask

   initial begin
      int ndone;
      logic [1:0]  o;
      logic [31:0] x, y;
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.a     = '0;
      bus.b     = '0;
      bus.flush = 1'b0;

      #12;
      chk("rst_busy", {31'd0, bus.busy}, 0);
      chk("rst_done", {31'd0, bus.done}, 0);
      chk("rst_result", bus.result, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_op("divu_100_7", OP_DIVU, 100, 7);
      run_op("remu_100_7", OP_REMU, 100, 7);
      run_op("div_m20_3", OP_DIV, 32'hFFFF_FFEC, 3);
      run_op("rem_m20_3", OP_REM, 32'hFFFF_FFEC, 3);
      run_op("divu_div0", OP_DIVU, 5, 0);
      run_op("rem_div0", OP_REM, 5, 0);
      run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001);

      // Idle flush does nothing; flush alongside start loses to start.
      bus.flush = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_flush_busy", {31'd0, bus.busy}, 0);
      chk("idle_flush_res", bus.result, 32'h1);
      issue(OP_DIVU, 40, 8);
      bus.flush = 1'b0;
      chk("start_wins_busy", {31'd0, bus.busy}, 1);
      wait_done("start_wins", 5, XLEN + 2);

      // Second start while busy is ignored.
      @(posedge clk);
      #1;
      issue(OP_DIVU, 100, 7);
      repeat (9) @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.op    = OP_DIVU;
      bus.a     = 50;
      bus.b     = 5;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done("ignore_start", 14, XLEN + 2 - 10);

      // Flush at cycle 20 aborts with no done and result held.
      @(posedge clk);
      #1;
      issue(OP_DIVU, 1000, 3);
      repeat (19) @(posedge clk);
      #1;
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      chk("flush_busy", {31'd0, bus.busy}, 0);
      chk("flush_done", {31'd0, bus.done}, 0);
      ndone = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.done) ndone++;
      end
      chk("flush_nodone", ndone, 0);
      chk("flush_res", bus.result, 14);

      // Asynchronous reset in the middle of an operation.
      issue(OP_DIVU, 100, 7);
      repeat (14) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", {31'd0, bus.busy}, 0);
      chk("mid_rst_done", {31'd0, bus.done}, 0);
      chk("mid_rst_res", bus.result, 0);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      run_op("post_rst", OP_DIVU, 9, 3);

      // Back-to-back: new start in the done cycle.
      issue(OP_REMU, 17, 5);
      wait_done("b2b_first", 2, XLEN + 2);
      issue(OP_DIVU, 17, 5);
      chk("b2b_pulse", {31'd0, bus.done}, 0);
      chk("b2b_held", bus.result, 2);
      chk("b2b_busy", {31'd0, bus.busy}, 1);
      wait_done("b2b_second", 3, XLEN + 2);
      @(posedge clk);
      #1;

      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom);
         x = $urandom;
         case ($urandom_range(0, 5))
            0: y = 0;
            1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            2: y = $urandom_range(1, 15);
            3: begin x = $urandom_range(0, 1000); y = $urandom; end
            default: y = $urandom;
         endcase
         run_op($sformatf("rnd%0d", i), o, x, y);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle iterative integer divider; the inverse-operation companion to the single-cycle ALU, which only provides multiply.
- Executes RV32M DIV/DIVU/REM/REMU using radix-2 restoring division, one quotient bit per cycle.
- Sits beside the ALU in the execute stage. The control path holds the pipeline via busy and consumes result when done pulses.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; accepted only in IDLE
op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
A  input  XLEN  dividend
B  input  XLEN  divisor
flush  input  1  synchronous abort of an in-flight operation
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse; result valid
result  output  XLEN  quotient or remainder, held until next completion

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, all internal registers 0.
- Reset mid-operation: the operation is discarded immediately; no done is produced.
- States: IDLE, PREP, CALC, FIN.
- IDLE:
  - start=1 at edge T0: latch A, B, op; go to PREP; busy=1 from T0.
  - start=0: stay in IDLE.
- PREP (edge T1):
  - Compute sign flags. Signed ops use A[XLEN-1] and B[XLEN-1]; unsigned ops use flags of 0.
  - Form absolute values and clear the remainder register; count=0.
  - Special cases go directly to FIN; all other operations go to CALC.
- Special cases, decided in PREP:
  - B==0: quotient = all ones for both DIV and DIVU; remainder = A.
  - op=DIV or REM with A=0x80000000 and B=0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- CALC (edges T2..T(XLEN+1)), one iteration per edge:
  - rem = {rem[XLEN-2:0], dvd[XLEN-1]}; dvd shifts left.
  - If rem >= divisor: rem -= divisor and shift in quotient bit 1; otherwise shift in 0.
  - Remainder compare and subtract are XLEN+1 bits wide, unsigned.
  - count increments each iteration; after iteration XLEN-1 go to FIN.
- FIN (edge T(XLEN+2) normal, T2 special):
  - Register result: quotient for DIV/DIVU, remainder for REM/REMU.
  - Quotient is negated when the dividend and divisor signs differ.
  - Remainder takes the sign of the dividend.
  - done=1 for exactly one cycle; busy=0 on the same edge; return to IDLE.
- Latency:
  - Normal: done asserted XLEN+2 cycles after the start edge.
  - Special case: done asserted 2 cycles after the start edge.
- start while busy=1: ignored; latched operands are not disturbed.
- Operand changes on A, B, op after acceptance have no effect.
- start on the cycle done=1: accepted, since the block is in IDLE. The new operation begins while result still holds the previous value.
- flush=1 in PREP, CALC or FIN: return to IDLE next edge; busy=0; done stays 0; result unchanged.
- flush=1 in IDLE: no effect.
- flush and start both high in IDLE: start wins.
- result changes only on the FIN edge.

Test Plan:
- DIVU A=100, B=7 -> done exactly 34 cycles after the start edge; result=14. Same operands with REMU -> result=2. busy high for 34 cycles.
- DIV A=0xFFFFFFEC (-20), B=3 -> result=0xFFFFFFFA (-6). REM with the same operands -> result=0xFFFFFFFE (-2).
- Special cases:
  - DIVU A=5, B=0 -> result=0xFFFFFFFF, done 2 cycles after start.
  - REM A=5, B=0 -> result=5.
  - DIV A=0x80000000, B=0xFFFFFFFF -> result=0x80000000.
  - REM with the same operands -> result=0.
- Start DIVU 100/7, then pulse start with 50/5 at cycle 10 -> second request ignored; result=14. Raise flush at cycle 20 -> busy=0 next cycle, no done pulse, result keeps its old value.
- Assert rst at cycle 15 of an operation -> busy, done and result are 0 immediately; after release a fresh DIVU 9/3 returns 3.
- Back-to-back: issue REMU 17/5, then assert start with DIVU 17/5 in the done cycle -> first result=2; second done pulse 34 cycles later with result=3.
